// File: rtl/divider16x8_pkg.sv
// ============================================================================
// Module   : divider16x8_pkg
// Purpose  : Shared state encodings and widths for the 16/8 restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef DIVIDER16X8_PKG_SV
`define DIVIDER16X8_PKG_SV

`default_nettype none

package divider16x8_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int STEP_COUNT = 8;
    localparam int DVD_W      = 16;
    localparam int DVS_W      = 8;

endpackage

`default_nettype wire

`endif

// File: rtl/divider16x8_subtractor9.sv
// ============================================================================
// Module   : subtractor9
// Purpose  : Combinational trial subtractor; borrow_o flags a < b.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module subtractor9 #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule

`default_nettype wire

// File: rtl/divider16x8.sv
// ============================================================================
// Module   : divider16x8
// Purpose  : Sequential restoring divider, 2*WIDTH / WIDTH, one quotient bit
//            per clock. Optional early overflow exit: define DIV_OVF_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider16x8
    import divider16x8_pkg::*;
#(
    parameter int WIDTH = DVS_W
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    localparam int CNT_W = $clog2(STEP_COUNT + 1);

    logic [1:0]        state_q,     state_d;
    logic [WIDTH:0]    r_q,         r_d;
    logic [WIDTH-1:0]  q_q,         q_d;
    logic [WIDTH-1:0]  d_q,         d_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic [WIDTH-1:0]  quotient_q,  quotient_d;
    logic [WIDTH-1:0]  remainder_q, remainder_d;
    logic              done_q,      done_d;
    logic              ovf_q,       ovf_d;
    logic              overflow_q,  overflow_d;

    logic [WIDTH:0]    trial;
    logic [WIDTH:0]    diff;
    logic              borrow;
    logic              r_msb_unused;

    // The top bit of R never feeds the next shift; it only exists so the
    // restored value keeps the full 9-bit partial remainder.
    assign trial        = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign r_msb_unused = r_q[WIDTH];

    subtractor9 #(
        .WIDTH    (WIDTH + 1)
    ) u_sub (
        .a_i      (trial),
        .b_i      ({1'b0, d_q}),
        .diff_o   (diff),
        .borrow_o (borrow)
    );

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    r_d     = {1'b0, dividend[2*WIDTH-1:WIDTH]};
                    q_d     = dividend[WIDTH-1:0];
                    d_d     = divisor;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = EXEC;
`ifdef DIV_OVF_CHECK_EN
                    // Quotient cannot fit (covers divisor == 0): skip the steps.
                    if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
                        r_d     = '0;
                        q_d     = '1;
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            EXEC: begin
                r_d     = borrow ? trial : diff;
                q_d     = {q_q[WIDTH-2:0], ~borrow};
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(STEP_COUNT - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                quotient_d  = q_q;
                remainder_d = r_q[WIDTH-1:0];
                overflow_d  = ovf_q;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!areset_n) begin
            state_q     <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            overflow_q  <= overflow_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q == EXEC);

endmodule

`default_nettype wire
